// File: rtl/sum_frame_accumulator.sv
// Frame accumulator for the 8-bit prefix-adder sum stream.
// Sums up to COUNT accepted samples and hands the total, count and carry flag downstream.
module sum_frame_accumulator #(
  parameter  int ACC_W = 16,
  parameter  int COUNT = 8,
  localparam int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_fire;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = enable & (state_q != S_HOLD);
  assign in_fire  = in_valid & in_ready;
  assign sum_ext  = {1'b0, acc_q} + (ACC_W + 1)'(in_data);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          acc_d   = ACC_W'(in_data);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (in_last || COUNT == 1) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_fire) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_inc;
          if (in_last || cnt_inc == CNT_W'(COUNT)) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers latch only on frame close, so they keep the last frame between results.
  always_comb begin
    out_valid_d = (state_d == S_HOLD);
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (state_q != S_HOLD && state_d == S_HOLD) begin
      out_data_d  = acc_d;
      out_count_d = cnt_d;
      out_ovf_d   = ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Bench for sum_frame_accumulator: a 16-bit and an 8-bit instance share stimulus and
// are compared every cycle against a frame-level model (sample queue, plain sums).
module tb_sum_frame_accumulator;

  localparam int COUNT = 8;

  logic        clock = 1'b0;
  logic        reset_n, enable, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_data16;
  logic [3:0]  out_count16;
  logic        in_ready8, out_valid8, out_ovf8;
  logic [7:0]  out_data8;
  logic [3:0]  out_count8;

  always #5 clock = ~clock;

  sum_frame_accumulator #(.ACC_W(16), .COUNT(COUNT)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_count(out_count16), .out_ovf(out_ovf16)
  );

  sum_frame_accumulator #(.ACC_W(8), .COUNT(COUNT)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .out_count(out_count8), .out_ovf(out_ovf8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: samples of the open frame, pending flag, last delivered result
  int q_frame[$];
  bit m_pend;
  int m_data16, m_data8, m_cnt;
  bit m_ovf16, m_ovf8;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_frame.delete();
    m_pend   = 1'b0;
    m_data16 = 0;
    m_data8  = 0;
    m_cnt    = 0;
    m_ovf16  = 1'b0;
    m_ovf8   = 1'b0;
  endtask

  task automatic cyc(input bit en, input bit iv, input int d, input bit last,
                     input bit ordy, input bit rstn);
    bit fire;
    int sum;
    @(negedge clock);
    enable    = en;
    in_valid  = iv;
    in_data   = 8'(d);
    in_last   = last;
    out_ready = ordy;
    reset_n   = rstn;
    #1;
    chk("in_ready16", int'(in_ready16), int'(en && !m_pend));
    chk("in_ready8",  int'(in_ready8),  int'(en && !m_pend));
    chk("out_valid16", int'(out_valid16), int'(m_pend));
    chk("out_valid8",  int'(out_valid8),  int'(m_pend));
    chk("out_data16",  int'(out_data16),  m_data16);
    chk("out_data8",   int'(out_data8),   m_data8);
    chk("out_count16", int'(out_count16), m_cnt);
    chk("out_count8",  int'(out_count8),  m_cnt);
    chk("out_ovf16",   int'(out_ovf16),   int'(m_ovf16));
    chk("out_ovf8",    int'(out_ovf8),    int'(m_ovf8));
    @(posedge clock);
    if (!rstn) begin
      model_reset();
    end else begin
      fire = iv && en && !m_pend;
      if (m_pend && ordy) m_pend = 1'b0;
      if (fire) begin
        q_frame.push_back(d & 255);
        if (last || q_frame.size() == COUNT) begin
          sum = 0;
          foreach (q_frame[i]) sum += q_frame[i];
          m_data16 = sum % 65536;
          m_ovf16  = (sum > 65535);
          m_data8  = sum % 256;
          m_ovf8   = (sum > 255);
          m_cnt    = q_frame.size();
          q_frame.delete();
          m_pend   = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 1, 1);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b0;

    // T1: reset, then 1..8
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_rst_valid", int'(out_valid16), 0);
    chk("t1_rst_data", int'(out_data16), 0);
    for (int i = 1; i <= 8; i++) cyc(1, 1, i, 0, 1, 1);
    chk("t1_valid", int'(out_valid16), 1);
    chk("t1_data", int'(out_data16), 36);
    chk("t1_count", int'(out_count16), 8);
    chk("t1_ovf", int'(out_ovf16), 0);
    idle(1);
    chk("t1_pulse", int'(out_valid16), 0);
    idle(1);

    // T2: 8 x 0xFF wraps the 8-bit instance
    for (int i = 0; i < 8; i++) cyc(1, 1, 255, 0, 1, 1);
    chk("t2_data8", int'(out_data8), 'hF8);
    chk("t2_ovf8", int'(out_ovf8), 1);
    chk("t2_data16", int'(out_data16), 2040);
    chk("t2_ovf16", int'(out_ovf16), 0);
    idle(2);
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 1, 1);
    chk("t2b_data8", int'(out_data8), 8);
    chk("t2b_ovf8", int'(out_ovf8), 0);
    idle(2);

    // T3: early close
    cyc(1, 1, 10, 0, 1, 1);
    cyc(1, 1, 20, 0, 1, 1);
    cyc(1, 1, 30, 1, 1, 1);
    chk("t3_data", int'(out_data16), 60);
    chk("t3_count", int'(out_count16), 3);
    idle(2);

    // T4: backpressure while beats wait upstream
    cyc(1, 1, 7, 1, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 9, 0, 0, 1);
    chk("t4_held", int'(out_data16), 7);
    cyc(1, 1, 9, 0, 1, 1);
    cyc(1, 1, 9, 0, 1, 1);
    cyc(1, 1, 9, 1, 1, 1);
    chk("t4_data", int'(out_data16), 18);
    idle(2);

    // T5: enable low mid-frame
    for (int i = 0; i < 3; i++) cyc(1, 1, 5, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 5, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 5, 0, 1, 1);
    chk("t5_data", int'(out_data16), 40);
    chk("t5_count", int'(out_count16), 8);
    idle(2);

    // T6: reset mid-frame and during HOLD
    for (int i = 0; i < 4; i++) cyc(1, 1, 3, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 0);
    chk("t6_mid_valid", int'(out_valid16), 0);
    chk("t6_mid_data", int'(out_data16), 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 2, 0, 0, 1);
    chk("t6_hold_valid", int'(out_valid16), 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t6_rst_valid", int'(out_valid16), 0);
    chk("t6_rst_count", int'(out_count16), 0);
    cyc(1, 1, 4, 0, 1, 1);
    cyc(1, 1, 6, 1, 1, 1);
    chk("t6_clean", int'(out_data16), 10);
    chk("t6_clean_cnt", int'(out_count16), 2);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
          int'($urandom_range(0, 255)), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
